fp_add_pipe: RTL
================

FP_ADD_PIPE -- requirements
Module: fp_add_pipe

Interface
REQ-001 SHALL have parameter PIPE_DEPTH, default 2, legal 1..4: number of register stages from input acceptance to output.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: operand pair present.
REQ-005 SHALL have port in_ready, output, 1 bit: operand pair accepted when in_valid && in_ready.
REQ-006 SHALL have ports fpa and fpb, input, 64 bits each: IEEE operands (binary64, or binary32 in bits [31:0] when db=1).
REQ-007 SHALL have port db, input, 1 bit: 1 selects single-precision operands; sampled with the operands.
REQ-008 SHALL have port sub, input, 1 bit: 1 computes fpa - fpb; sampled with the operands.
REQ-009 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): result handshake.
REQ-010 SHALL have output es, 11 bits: biased binary64 exponent of the unnormalised result.
REQ-011 SHALL have output fs, 57 bits: unrounded significand; [56:55] integer, [54:3] fraction, [2] guard, [1] round, [0] sticky.
REQ-012 SHALL have outputs ss (1 bit, result sign) and fls (2 bits: 00 finite nonzero, 01 zero, 10 infinity, 11 NaN).

Function
REQ-013 SHALL advance all stages when adv = !out_valid || out_ready; in_ready SHALL equal adv.
REQ-014 SHALL present a result exactly PIPE_DEPTH adv-cycles after acceptance, in acceptance order, with no loss or duplication.
REQ-015 SHALL hold es/fs/ss/fls/out_valid stable while out_valid && !out_ready.
REQ-016 SHALL carry a valid bit per stage; bubbles propagate and are not collapsed.
REQ-017 Unpack, db=0: hidden bit = (e!=0); zero/denormal exponent treated as 1.
REQ-018 Unpack, db=1: e8 rebiased to e8+896; zero/denormal exponent 897; 23-bit fraction left-justified into 52 bits.
REQ-019 Effective sign of b SHALL be sb ^ sub.
REQ-020 Larger magnitude operand (exponent, then significand) SHALL be the big operand; es = its exponent; ss = its sign.
REQ-021 Smaller operand SHALL shift right by d = exponent difference; bits below round position SHALL OR into sticky; d>=56 leaves only sticky = (significand!=0).
REQ-022 Equal effective signs: fs = big + small; otherwise fs = big - small (never negative).
REQ-023 fs == 0 from finite operands: fls=01, es=0, ss=0, except both operands -0 with equal effective signs, which gives ss=1.
REQ-024 Either operand NaN, or inf with opposite-signed effective inf: fls=11, es=2047, fs = 2'b01,1,51'b0,3'b0, ss=0.
REQ-025 Exactly one infinity, or same-signed infinities: fls=10, es=2047, fs=0, ss = infinity sign.
REQ-026 No rounding or normalisation SHALL occur in this block.

Reset
REQ-027 While rst=1 at a clock edge: all stage valid bits, out_valid, es, fs, ss, fls SHALL clear to 0.
REQ-028 Reset mid-operation SHALL discard all in-flight operations; no result SHALL appear for them.
REQ-029 During reset, in_ready SHALL read 1 (out_valid=0); inputs presented in the reset cycle SHALL NOT be accepted.

Verification
REQ-030 db=0, sub=0, fpa=fpb=0x3FF0000000000000 -> after PIPE_DEPTH cycles es=0x3FF, fs=0x100000000000000, ss=0, fls=00.
REQ-031 db=0, sub=1, fpa=fpb=0x3FF0000000000000 -> es=0, fs=0, ss=0, fls=01.
REQ-032 db=1, fpa=0x3F800000, fpb=0x40000000, sub=0 -> es=1024, fs=0x0C0000000000000, ss=0, fls=00.
REQ-033 fpa=0x7FF0000000000000, fpb=0xFFF0000000000000, sub=0 -> fls=11, es=2047; with sub=1 -> fls=10, ss=0.
REQ-034 Stream 8 back-to-back ops, out_ready low for 5 cycles mid-stream -> in_ready low while stalled, output stable, all 8 results in order.
REQ-035 Assert rst one cycle with PIPE_DEPTH ops in flight -> out_valid=0 next cycle, no stale result ever emitted.

Source files
------------

// File: rtl/fp_add_pipe.sv
// Pipelined IEEE binary64/binary32 adder front end: unpack, align, add/subtract.
// Produces an unrounded, unnormalised result plus class flags; rounding happens downstream.
module fp_add_pipe #(
  parameter int PIPE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] fpa,
  input  logic [63:0] fpb,
  input  logic        db,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] es,
  output logic [56:0] fs,
  output logic        ss,
  output logic [1:0]  fls
);

  typedef struct packed {
    logic        sign;
    logic [10:0] exp;
    logic [52:0] sig;
    logic        nan;
    logic        inf;
  } opnd_t;

  typedef struct packed {
    logic        vld;
    logic [10:0] es;
    logic [56:0] fs;
    logic        ss;
    logic [1:0]  fls;
  } stage_t;

  localparam logic [1:0] FLS_FIN  = 2'b00;
  localparam logic [1:0] FLS_ZERO = 2'b01;
  localparam logic [1:0] FLS_INF  = 2'b10;
  localparam logic [1:0] FLS_NAN  = 2'b11;

  // Single-precision operands are widened onto the binary64 exponent/significand grid.
  function automatic opnd_t unpack(input logic [63:0] x, input logic is_sp);
    opnd_t u;
    if (is_sp) begin
      u.sign = x[31];
      u.exp  = (x[30:23] == 8'd0) ? 11'd897 : {3'b000, x[30:23]} + 11'd896;
      u.sig  = {x[30:23] != 8'd0, x[22:0], 29'd0};
      u.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      u.inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    end else begin
      u.sign = x[63];
      u.exp  = (x[62:52] == 11'd0) ? 11'd1 : x[62:52];
      u.sig  = {x[62:52] != 11'd0, x[51:0]};
      u.nan  = (&x[62:52]) && (x[51:0] != 52'd0);
      u.inf  = (&x[62:52]) && (x[51:0] == 52'd0);
    end
    return u;
  endfunction

  opnd_t        op_a, op_b, big_op, small_op;
  logic         same_sign, a_big;
  logic [10:0]  exp_diff;
  logic [6:0]   shamt;
  logic [111:0] shifted;
  logic [56:0]  big_ext, small_ext, mag;
  stage_t       res_d;
  logic         adv;

  always_comb begin
    op_a      = unpack(fpa, db);
    op_b      = unpack(fpb, db);
    op_b.sign = op_b.sign ^ sub;
    same_sign = (op_a.sign == op_b.sign);
    a_big     = {op_a.exp, op_a.sig} >= {op_b.exp, op_b.sig};
    big_op    = a_big ? op_a : op_b;
    small_op  = a_big ? op_b : op_a;
    exp_diff  = big_op.exp - small_op.exp;
    shamt     = (exp_diff >= 11'd56) ? 7'd56 : exp_diff[6:0];
    // Upper 56 bits hold the aligned significand+GRS; everything shifted below folds into sticky.
    shifted   = {small_op.sig, 59'd0} >> shamt;
    big_ext   = {1'b0, big_op.sig, 3'b000};
    small_ext = {1'b0, shifted[111:57], shifted[56] | (|shifted[55:0])};
    mag       = same_sign ? (big_ext + small_ext) : (big_ext - small_ext);

    res_d     = '0;
    res_d.vld = in_valid;
    if (op_a.nan || op_b.nan || (op_a.inf && op_b.inf && !same_sign)) begin
      res_d.es  = 11'h7FF;
      res_d.fs  = {2'b01, 1'b1, 54'd0};
      res_d.fls = FLS_NAN;
    end else if (op_a.inf || op_b.inf) begin
      res_d.es  = 11'h7FF;
      res_d.ss  = op_a.inf ? op_a.sign : op_b.sign;
      res_d.fls = FLS_INF;
    end else if (mag == 57'd0) begin
      // Only -0 + -0 (after effective sign) keeps a negative zero.
      res_d.ss  = same_sign & op_a.sign;
      res_d.fls = FLS_ZERO;
    end else begin
      res_d.es  = big_op.exp;
      res_d.fs  = mag;
      res_d.ss  = big_op.sign;
      res_d.fls = FLS_FIN;
    end
  end

  stage_t stg_q [PIPE_DEPTH];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
    stage_t stg_d;
    if (gi == 0) begin : g_head
      assign stg_d = res_d;
    end else begin : g_tail
      assign stg_d = stg_q[gi-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        stg_q[gi] <= '0;
      end else if (adv) begin
        stg_q[gi] <= stg_d;
      end
    end
  end

  assign out_valid = stg_q[PIPE_DEPTH-1].vld;
  assign es        = stg_q[PIPE_DEPTH-1].es;
  assign fs        = stg_q[PIPE_DEPTH-1].fs;
  assign ss        = stg_q[PIPE_DEPTH-1].ss;
  assign fls       = stg_q[PIPE_DEPTH-1].fls;

endmodule
